pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 6-stage RV32 pipeline (F, D, E, B, M, W).
- Drives the stall enables and synchronous clear inputs of every inter-stage pipeline register.
- Resolves load-use hazards, B-stage control redirects and multi-cycle data-memory waits.
- Sits beside the forwarding unit; contains no datapath.

Parameters:
WAIT_W, 8, width of memory-wait cycle counter
MAX_WAIT, 200, wait cycles after which MemTimeout is raised (must be < 2**WAIT_W)
CNT_W, 32, width of performance counters (PERF_CNT_EN only)

Ports:
clk  in  1  pipeline clock
reset_n  in  1  asynchronous active-low reset
Rs1D, Rs2D  in  5  source registers of instruction in D
RdE, RdB  in  5  destinations in E and B
RegWriteE, RegWriteB  in  1  register-write flags in E and B
ResultSrcE, ResultSrcB  in  3  result select; 3'b001 = load
PCSrcB  in  1  taken branch/jump resolved in B
MemReqM  in  1  data-memory access in M
MemReadyM  in  1  data-memory ready for M access
StallF, StallD, StallE, StallB, StallM  out  1  hold PC / pipeline register
FlushD, FlushE, FlushB, FlushW  out  1  synchronous clear of D, E, B, W registers
MemTimeout  out  1  sticky wait-timeout flag
StallCycles, FlushEvents  out  CNT_W  performance counters (PERF_CNT_EN only)

Behaviour:
- Stall/flush outputs are combinational from inputs and registered state: same-cycle effect. Registered state: FSM, wait counter, MemTimeout, perf counters.
- Reset (reset_n low, async): state RUN, wait counter 0, MemTimeout 0, counters 0. Every Stall*/Flush* output reads 0 during reset.
- FSM states:
  - RUN: normal operation.
  - MEMWAIT: memory stall in progress.
- FSM transitions:
  - RUN -> MEMWAIT when MemReqM & !MemReadyM.
  - MEMWAIT -> RUN on first cycle with MemReadyM=1.
- MEMWAIT outputs, including the RUN cycle that detects the wait:
  - StallF/D/E/B/M=1, FlushW=1 (bubble into W); all other flushes 0.
  - Wait counter increments per stalled cycle, saturating at all-ones; it clears on return to RUN.
  - When the count reaches MAX_WAIT, MemTimeout sets and stays set until reset.
- Memory stall has the highest priority. Redirect and load-use are suppressed while memory-stalled. The B register holds, so PCSrcB is re-presented after release and its effect is deferred.
- Redirect (no memory stall, PCSrcB=1): FlushD=FlushE=FlushB=1, all stalls 0, for exactly the cycle PCSrcB is high. Wrong-path instructions in F/D/E are discarded.
- Load-use (no memory stall, no redirect):
  - LE = RegWriteE & ResultSrcE==3'b001 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
  - LB = the same test using the B-stage signals.
  - If LE|LB: StallF=StallD=1, FlushE=1.
  - A load in E against a dependent in D yields 2 bubbles: first LE, then LB on the next cycle.
  - x0 never triggers a stall.
- Redirect and load-use in the same cycle: redirect wins; no stall.
- Memory ready in the same cycle as request: no stall, FSM stays RUN.
- Reset asserted mid-MEMWAIT: immediate return to RUN, counter cleared.

Optional Feature:
PERF_CNT_EN
- Defined: StallCycles increments every cycle StallF=1. FlushEvents increments every cycle with a redirect flush. Both wrap modulo 2**CNT_W and reset to 0.
- Undefined: both outputs are tied to 0 and the counters are not instantiated.

Decomposition:
- Shared package (pipe_ctrl_pkg):
  - RESULT_SRC_LOAD = 3'b001
  - hz_state_t enum {RUN, MEMWAIT}
  - REG_X0 = 5'd0
- One sub-module: hz_loaduse_cmp, the combinational per-stage load-use comparator, instantiated twice (E and B). Everything else stays inline.

Test Plan:
- Reset: reset_n=0 mid-MEMWAIT with counter=5 -> all outputs 0 immediately. After release: state RUN, counter 0, MemTimeout 0.
- Load-use: E holds load RdE=5, D holds Rs1D=5 -> cycle 0: StallF/D=1, FlushE=1. Cycle 1: LB path repeats. Cycle 2: all 0. Same with RdE=0 -> no stall.
- Redirect: PCSrcB=1 for 1 cycle with LE also true -> FlushD/E/B=1, StallF=0, no load-use bubble.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> StallF..M=1 and FlushW=1 for 3 cycles; cycle 4 all 0; FSM back in RUN.
- Deferred redirect: PCSrcB=1 during a memory wait -> no flush while stalled; FlushD/E/B=1 on the first release cycle.
- Timeout: MemReadyM held 0 for MAX_WAIT=200 cycles -> MemTimeout=1 from cycle 200, still 1 after MemReadyM=1.
- With PERF_CNT_EN: after the above -> StallCycles equals the counted stall cycles, FlushEvents = 2.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard sequencer.
// Holds the load result-select code, the x0 index and the FSM state type.
package pipe_ctrl_pkg;

  localparam logic [2:0] RESULT_SRC_LOAD = 3'b001;
  localparam logic [4:0] REG_X0          = 5'd0;

  typedef enum logic {
    RUN,
    MEMWAIT
  } hz_state_t;

endpackage

// File: rtl/hz_loaduse_cmp.sv
// Per-stage load-use comparator: flags a load in this stage whose destination
// feeds a source of D. Ports: write/select/rd of the stage, rs1/rs2 of D, hit_o.
module hz_loaduse_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic       RegWrite_i,
  input  logic [2:0] ResultSrc_i,
  input  logic [4:0] Rd_i,
  input  logic [4:0] Rs1_i,
  input  logic [4:0] Rs2_i,
  output logic       hit_o
);

  logic is_load;
  logic rd_match;

  assign is_load  = RegWrite_i && (ResultSrc_i == RESULT_SRC_LOAD);
  assign rd_match = (Rd_i == Rs1_i) || (Rd_i == Rs2_i);
  assign hit_o    = is_load && (Rd_i != REG_X0) && rd_match;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the F-D-E-B-M-W pipeline: load-use, B-stage redirect,
// memory-wait FSM with sticky timeout. Optional perf counters under PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 200,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdB,
  input  logic             RegWriteE,
  input  logic             RegWriteB,
  input  logic [2:0]       ResultSrcE,
  input  logic [2:0]       ResultSrcB,
  input  logic             PCSrcB,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallB,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushB,
  output logic             FlushW,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushEvents
);

  localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

  hz_state_t         state_q, state_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic              tmo_q, tmo_d;

  logic lu_e, lu_b;
  logic mem_stall;
  logic redirect;
  logic load_use;

  hz_loaduse_cmp u_cmp_e (
    .RegWrite_i  (RegWriteE),
    .ResultSrc_i (ResultSrcE),
    .Rd_i        (RdE),
    .Rs1_i       (Rs1D),
    .Rs2_i       (Rs2D),
    .hit_o       (lu_e)
  );

  hz_loaduse_cmp u_cmp_b (
    .RegWrite_i  (RegWriteB),
    .ResultSrc_i (ResultSrcB),
    .Rd_i        (RdB),
    .Rs1_i       (Rs1D),
    .Rs2_i       (Rs2D),
    .hit_o       (lu_b)
  );

  // The detecting RUN cycle already stalls; in MEMWAIT the
  // first ready cycle releases without a stall.
  assign mem_stall = ((state_q == MEMWAIT) || MemReqM)
                     && !MemReadyM;
  assign redirect  = !mem_stall && PCSrcB;
  assign load_use  = !mem_stall && !PCSrcB && (lu_e || lu_b);

  // Gate with reset_n so no control leaks out while in reset.
  assign StallF = reset_n && (mem_stall || load_use);
  assign StallD = reset_n && (mem_stall || load_use);
  assign StallE = reset_n && mem_stall;
  assign StallB = reset_n && mem_stall;
  assign StallM = reset_n && mem_stall;
  assign FlushD = reset_n && redirect;
  assign FlushE = reset_n && (redirect || load_use);
  assign FlushB = reset_n && redirect;
  assign FlushW = reset_n && mem_stall;

  assign MemTimeout = tmo_q;

  always_comb begin
    state_d = mem_stall ? MEMWAIT : RUN;
    wcnt_d  = '0;
    if (mem_stall) begin
      wcnt_d = (wcnt_q == '1) ? wcnt_q : wcnt_q + 1'b1;
    end
    tmo_d = tmo_q || (mem_stall && (wcnt_d >= MAX_W));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (redirect) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushEvents = flush_cnt_q;
`else
  assign StallCycles = '0;
  assign FlushEvents = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed and random cycles against a
// behavioural model; a negedge monitor pops expected values and compares.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [4:0]  Rs1D, Rs2D, RdE, RdB;
  logic        RegWriteE, RegWriteB;
  logic [2:0]  ResultSrcE, ResultSrcB;
  logic        PCSrcB, MemReqM, MemReadyM;
  logic        StallF, StallD, StallE, StallB, StallM;
  logic        FlushD, FlushE, FlushB, FlushW;
  logic        MemTimeout;
  logic [31:0] StallCycles, FlushEvents;

  pipe_hazard_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .RdE         (RdE),
    .RdB         (RdB),
    .RegWriteE   (RegWriteE),
    .RegWriteB   (RegWriteB),
    .ResultSrcE  (ResultSrcE),
    .ResultSrcB  (ResultSrcB),
    .PCSrcB      (PCSrcB),
    .MemReqM     (MemReqM),
    .MemReadyM   (MemReadyM),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallB      (StallB),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushB      (FlushB),
    .FlushW      (FlushW),
    .MemTimeout  (MemTimeout),
    .StallCycles (StallCycles),
    .FlushEvents (FlushEvents)
  );

  typedef struct packed {
    logic [4:0] rs1, rs2, rde, rdb;
    logic       rwe, rwb;
    logic [2:0] rse, rsb;
    logic       pc, req, rdy, rst_n;
  } stim_t;

  // ctl = {StallF,StallD,StallE,StallB,StallM,FlushD,FlushE,FlushB,FlushW}
  typedef struct packed {
    logic [8:0]  ctl;
    logic        to;
    logic [31:0] sc, fe;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: "currently waiting on memory", cycles waited so far,
  // sticky timeout and the two event tallies.
  bit          m_wait;
  int          m_cnt;
  bit          m_to;
  logic [31:0] m_sc, m_fe;

  function automatic bit dep_load(logic rw, logic [2:0] rs, logic [4:0] rd,
                                  logic [4:0] a, logic [4:0] b);
    return rw && (rs == 3'b001) && (rd != 5'd0) && (rd == a || rd == b);
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    s.rdy = 1'b1;
    return s;
  endfunction

  task automatic cyc(input stim_t s);
    exp_t e;
    bit   mem, red, luse;
    @(posedge clk);
    #1;
    reset_n    = s.rst_n;
    Rs1D       = s.rs1;
    Rs2D       = s.rs2;
    RdE        = s.rde;
    RdB        = s.rdb;
    RegWriteE  = s.rwe;
    RegWriteB  = s.rwb;
    ResultSrcE = s.rse;
    ResultSrcB = s.rsb;
    PCSrcB     = s.pc;
    MemReqM    = s.req;
    MemReadyM  = s.rdy;
    e = '0;
    if (!s.rst_n) begin
      m_wait = 0;
      m_cnt  = 0;
      m_to   = 0;
      m_sc   = '0;
      m_fe   = '0;
    end else begin
      mem  = !s.rdy && (m_wait || s.req);
      red  = !mem && s.pc;
      luse = !mem && !s.pc &&
             (dep_load(s.rwe, s.rse, s.rde, s.rs1, s.rs2) ||
              dep_load(s.rwb, s.rsb, s.rdb, s.rs1, s.rs2));
      e.ctl = {mem | luse, mem | luse, mem, mem, mem,
               red, red | luse, red, mem};
      e.to = m_to;
`ifdef PERF_CNT_EN
      e.sc = m_sc;
      e.fe = m_fe;
`endif
      if (mem) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt >= 200) m_to = 1;
      end else begin
        m_cnt = 0;
      end
      m_wait = mem;
      if (mem || luse) m_sc++;
      if (red) m_fe++;
    end
    q.push_back(e);
  endtask

  function automatic stim_t rnd();
    stim_t s;
    s = idle();
    s.rs1 = 5'($urandom_range(0, 3));
    s.rs2 = 5'($urandom_range(0, 3));
    s.rde = 5'($urandom_range(0, 3));
    s.rdb = 5'($urandom_range(0, 3));
    s.rwe = 1'($urandom);
    s.rwb = 1'($urandom);
    s.rse = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'($urandom);
    s.rsb = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'($urandom);
    s.pc  = ($urandom_range(0, 99) < 15);
    s.req = ($urandom_range(0, 99) < 30);
    s.rdy = ($urandom_range(0, 99) < 65);
    s.rst_n = ($urandom_range(0, 199) != 0);
    return s;
  endfunction

  // Monitor: compares DUT outputs mid-cycle against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    logic [8:0] act;
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {StallF, StallD, StallE, StallB, StallM,
             FlushD, FlushE, FlushB, FlushW};
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL ctl @%0t: got %b expected %b", $time, act, e.ctl);
      end
      checks++;
      if (MemTimeout !== e.to) begin
        errors++;
        $display("FAIL timeout @%0t: got %b expected %b",
                 $time, MemTimeout, e.to);
      end
      checks++;
      if (StallCycles !== e.sc) begin
        errors++;
        $display("FAIL stallcyc @%0t: got %0d expected %0d",
                 $time, StallCycles, e.sc);
      end
      checks++;
      if (FlushEvents !== e.fe) begin
        errors++;
        $display("FAIL flushevt @%0t: got %0d expected %0d",
                 $time, FlushEvents, e.fe);
      end
    end
  end

  initial begin
    stim_t s;
    reset_n = 1'b0;
    Rs1D = '0; Rs2D = '0; RdE = '0; RdB = '0;
    RegWriteE = 0; RegWriteB = 0;
    ResultSrcE = '0; ResultSrcB = '0;
    PCSrcB = 0; MemReqM = 0; MemReadyM = 1;
    m_wait = 0; m_cnt = 0; m_to = 0; m_sc = '0; m_fe = '0;

    s = idle(); s.rst_n = 0;
    cyc(s); cyc(s);
    cyc(idle());

    // Load in E feeding D: LE bubble, then LB bubble, then clear.
    s = idle(); s.rwe = 1; s.rse = 3'b001; s.rde = 5; s.rs1 = 5;
    cyc(s);
    s = idle(); s.rwb = 1; s.rsb = 3'b001; s.rdb = 5; s.rs1 = 5;
    cyc(s);
    cyc(idle());
    s = idle(); s.rwe = 1; s.rse = 3'b001; s.rde = 0; s.rs1 = 0;
    cyc(s);

    // Redirect beats a simultaneous load-use.
    s = idle(); s.rwe = 1; s.rse = 3'b001; s.rde = 7; s.rs2 = 7;
    s.pc = 1;
    cyc(s);
    cyc(idle());

    // Three-cycle memory wait, then release.
    s = idle(); s.req = 1; s.rdy = 0;
    repeat (3) cyc(s);
    s.rdy = 1;
    cyc(s);
    cyc(idle());

    // Same-cycle ready: no stall.
    s = idle(); s.req = 1; s.rdy = 1;
    cyc(s);

    // Redirect deferred until the wait releases.
    s = idle(); s.req = 1; s.rdy = 0; s.pc = 1;
    repeat (2) cyc(s);
    s.rdy = 1;
    cyc(s);
    cyc(idle());

    // Timeout: hold off ready past MAX_WAIT, flag stays sticky.
    s = idle(); s.req = 1; s.rdy = 0;
    repeat (205) cyc(s);
    s.rdy = 1;
    cyc(s);
    repeat (2) cyc(idle());

    // Reset in the middle of a wait.
    s = idle(); s.req = 1; s.rdy = 0;
    repeat (5) cyc(s);
    s.rst_n = 0;
    cyc(s);
    repeat (2) cyc(idle());

    repeat (3000) cyc(rnd());

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
